// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush-to-bubble
// and an optional two-entry skid buffer that registers upstream ready.
module pipe_stage_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter bit               SKID       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_flush,
    output logic [1:0]       o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    generate
        if (SKID) begin : g_skid
            state_t           state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             rdy_q, rdy_d;
            logic             up, down;

            assign up      = i_valid & rdy_q;
            assign down    = (state_q != EMPTY) & i_ready;
            assign o_ready = rdy_q;
            assign o_valid = (state_q != EMPTY);
            assign o_data  = main_q;
            assign o_count = state_q;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                rdy_d   = rdy_q;
                case (state_q)
                    EMPTY: begin
                        if (up) begin
                            main_d  = i_data;
                            state_d = BUSY;
                        end
                    end
                    BUSY: begin
                        if (up && down) begin
                            main_d = i_data;
                        end else if (up) begin
                            skid_d  = i_data;
                            state_d = FULL;
                            rdy_d   = 1'b0;
                        end else if (down) begin
                            main_d  = BUBBLE_VAL;
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (down) begin
                            main_d  = skid_q;
                            skid_d  = BUBBLE_VAL;
                            state_d = BUSY;
                            rdy_d   = 1'b1;
                        end
                    end
                    default: begin
                        main_d  = BUBBLE_VAL;
                        skid_d  = BUBBLE_VAL;
                        state_d = EMPTY;
                        rdy_d   = 1'b1;
                    end
                endcase
                // Flush wins over any same-cycle up beat; a down beat has already been taken.
                if (i_flush) begin
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                    state_d = EMPTY;
                    rdy_d   = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= EMPTY;
                    main_q  <= BUBBLE_VAL;
                    skid_q  <= BUBBLE_VAL;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                    rdy_q   <= rdy_d;
                end
            end
        end else begin : g_single
            logic [WIDTH-1:0] main_q, main_d;
            logic             vld_q, vld_d;
            logic             up, down;

            assign o_ready = ~vld_q | i_ready;
            assign up      = i_valid & o_ready;
            assign down    = vld_q & i_ready;
            assign o_valid = vld_q;
            assign o_data  = main_q;
            assign o_count = {1'b0, vld_q};

            always_comb begin
                main_d = main_q;
                vld_d  = vld_q;
                if (i_flush) begin
                    main_d = BUBBLE_VAL;
                    vld_d  = 1'b0;
                end else if (up) begin
                    main_d = i_data;
                    vld_d  = 1'b1;
                end else if (down) begin
                    main_d = BUBBLE_VAL;
                    vld_d  = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_q <= BUBBLE_VAL;
                    vld_q  <= 1'b0;
                end else begin
                    main_q <= main_d;
                    vld_q  <= vld_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid variant (dut) and single-entry variant (dut0).
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_flush, o_ready, o_valid;
    logic [31:0] i_data, o_data;
    logic [1:0]  o_count;
    logic        v0, r0, f0, ordy0, ovld0;
    logic [31:0] d0, odat0;
    logic [1:0]  ocnt0;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .BUBBLE_VAL(BUB), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .i_flush(i_flush),
        .o_count(o_count)
    );

    pipe_stage_reg #(.WIDTH(32), .BUBBLE_VAL(BUB), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i_valid(v0), .o_ready(ordy0), .i_data(d0),
        .o_valid(ovld0), .i_ready(r0), .o_data(odat0), .i_flush(f0),
        .o_count(ocnt0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] c, input logic r);
        chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
        chk({tag, ".data"}, o_data, d);
        chk({tag, ".count"}, {30'd0, o_count}, {30'd0, c});
        chk({tag, ".ready"}, {31'd0, o_ready}, {31'd0, r});
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_ready = 1'b0; i_flush = 1'b0;
        v0 = 1'b0; d0 = '0; r0 = 1'b0; f0 = 1'b0;
        tick();
        rst = 1'b0; i_valid = 1'b0;
        chk_out("reset", 1'b0, BUB, 2'd0, 1'b1);

        // Idle stage ignores payload when i_valid is low
        i_data = 32'hFFFF_FFFF;
        tick();
        chk_out("idle", 1'b0, BUB, 2'd0, 1'b1);

        // Streaming at full throughput
        i_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            i_valid = 1'b1; i_data = k;
            tick();
            chk_out($sformatf("stream%0d", k), 1'b1, k, 2'd1, 1'b1);
        end
        i_valid = 1'b0;
        tick();
        chk_out("drain", 1'b0, BUB, 2'd0, 1'b1);

        // Stall fills the skid entry
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA;
        tick();
        chk_out("stallA", 1'b1, 32'hA, 2'd1, 1'b1);
        i_data = 32'hB;
        tick();
        chk_out("stallB", 1'b1, 32'hA, 2'd2, 1'b0);
        i_valid = 1'b0; i_data = 32'hEE;
        tick();
        chk_out("hold", 1'b1, 32'hA, 2'd2, 1'b0);
        i_ready = 1'b1;
        tick();
        chk_out("relA", 1'b1, 32'hB, 2'd1, 1'b1);
        tick();
        chk_out("relB", 1'b0, BUB, 2'd0, 1'b1);

        // Flush while FULL with an offered beat
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA;
        tick();
        i_data = 32'hB;
        tick();
        i_flush = 1'b1; i_data = 32'hC;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        chk_out("flushF", 1'b0, BUB, 2'd0, 1'b1);
        i_ready = 1'b1;
        tick();
        chk_out("flushNoC", 1'b0, BUB, 2'd0, 1'b1);

        // Flush while BUSY drops the accepted same-cycle beat; down beat completes
        i_valid = 1'b1; i_data = 32'h11;
        tick();
        chk_out("busy", 1'b1, 32'h11, 2'd1, 1'b1);
        i_flush = 1'b1; i_data = 32'h22;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        chk_out("flushB", 1'b0, BUB, 2'd0, 1'b1);

        // Reset mid-stall, then a new push
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA;
        tick();
        i_data = 32'hB;
        tick();
        rst = 1'b1; i_data = 32'hC;
        tick();
        rst = 1'b0;
        chk_out("rstFull", 1'b0, BUB, 2'd0, 1'b1);
        i_data = 32'h7;
        tick();
        i_valid = 1'b0;
        chk_out("push7", 1'b1, 32'h7, 2'd1, 1'b1);
        i_ready = 1'b1;
        tick();
        chk_out("pop7", 1'b0, BUB, 2'd0, 1'b1);

        // Single-entry variant: combinational ready
        chk("s0.reset", {31'd0, ovld0}, 32'd0);
        v0 = 1'b1; d0 = 32'h9;
        tick();
        chk("s0.data9", odat0, 32'h9);
        chk("s0.cnt1", {30'd0, ocnt0}, 32'd1);
        v0 = 1'b0;
        #1;
        chk("s0.rdyLo", {31'd0, ordy0}, 32'd0);
        r0 = 1'b1;
        #1;
        chk("s0.rdyHi", {31'd0, ordy0}, 32'd1);
        v0 = 1'b1; d0 = 32'h5;
        tick();
        chk("s0.data5", odat0, 32'h5);
        chk("s0.vld5", {31'd0, ovld0}, 32'd1);
        chk("s0.cnt5", {30'd0, ocnt0}, 32'd1);
        v0 = 1'b0;
        tick();
        chk("s0.dataE", odat0, BUB);
        chk("s0.vldE", {31'd0, ovld0}, 32'd0);
        chk("s0.cntE", {30'd0, ocnt0}, 32'd0);
        v0 = 1'b1; d0 = 32'h6; r0 = 1'b0;
        tick();
        f0 = 1'b1; v0 = 1'b0;
        tick();
        f0 = 1'b0;
        chk("s0.flush", odat0, BUB);
        chk("s0.flushV", {31'd0, ovld0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
